set_assoc_cache_model: RTL and testbench

Parametrised N-way set-associative cache tag model. It succeeds the direct-mapped hit counter and is driven by address traces in trace-replay benches. Each address presented on a valid/ready handshake is looked up, and the block returns hit/miss one cycle later. Tag and LRU state are updated, and saturating totals plus per-window hit counts are kept for periodic logging. No data storage; tags and valid bits only.

---
 rtl/set_assoc_cache_model_pkg.sv | 40 ++++
 rtl/set_assoc_cache_model_if.sv | 13 +
 rtl/set_assoc_cache_model_lru.sv | 53 +++++
 rtl/set_assoc_cache_model.sv | 153 +++++++++++++++
 tb/tb_set_assoc_cache_model.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/set_assoc_cache_model_pkg.sv
// Shared types, width helpers and address/counter functions for the
// set-associative cache tag model.
package cache_model_pkg;

    typedef enum logic {INIT, RUN} state_t;

    localparam int MAX_ADDR_W = 64;

    function automatic int age_width(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

    function automatic int tag_width(input int addr_w, input int off_bits, input int idx_bits);
        return addr_w - off_bits - idx_bits;
    endfunction

    // Widths of the default configuration (32-bit address, 256 sets, 2 ways)
    localparam int TAG_W = tag_width(32, 2, 8);
    localparam int AGE_W = age_width(2);

    function automatic logic [MAX_ADDR_W-1:0] addr_tag(input logic [MAX_ADDR_W-1:0] addr,
                                                       input int off_bits, input int idx_bits);
        return addr >> (off_bits + idx_bits);
    endfunction

    function automatic logic [MAX_ADDR_W-1:0] addr_index(input logic [MAX_ADDR_W-1:0] addr,
                                                         input int off_bits, input int idx_bits);
        return (addr >> off_bits) & ((MAX_ADDR_W'(1) << idx_bits) - MAX_ADDR_W'(1));
    endfunction

    function automatic logic [MAX_ADDR_W-1:0] sat_inc(input logic [MAX_ADDR_W-1:0] val,
                                                      input logic inc, input int width);
        logic [MAX_ADDR_W-1:0] max_val;
        max_val = (MAX_ADDR_W'(1) << width) - MAX_ADDR_W'(1);
        if (inc && (val != max_val))
            return val + MAX_ADDR_W'(1);
        return val;
    endfunction

endpackage

// File: rtl/set_assoc_cache_model_if.sv
// Request/response handshake between a trace driver and the cache tag model.
interface set_assoc_cache_model_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic              req_ready;
    logic              resp_valid;
    logic              resp_hit;

    modport master (output req_valid, req_addr, input req_ready, resp_valid, resp_hit);
    modport slave  (input req_valid, req_addr, output req_ready, resp_valid, resp_hit);
endinterface

// File: rtl/set_assoc_cache_model_lru.sv
// Combinational victim choice and age-based LRU update for one set.
module lru_age_update
    import cache_model_pkg::*;
#(
    parameter int WAYS     = 2,
    parameter int AGE_BITS = age_width(WAYS)
) (
    input  logic [WAYS-1:0][AGE_BITS-1:0] age_vec,
    input  logic [WAYS-1:0]               valid_vec,
    input  logic                          hit,
    input  logic [AGE_BITS-1:0]           hit_way,
    output logic [AGE_BITS-1:0]           victim_way,
    output logic [WAYS-1:0][AGE_BITS-1:0] next_age
);
    logic                found_invalid;
    logic [AGE_BITS-1:0] max_age;
    logic [AGE_BITS-1:0] access_way;
    logic [AGE_BITS-1:0] access_age;

    // Lowest invalid way wins; otherwise the oldest (ties go to the lower index)
    always_comb begin
        victim_way    = '0;
        found_invalid = 1'b0;
        max_age       = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_vec[w]) begin
                victim_way    = AGE_BITS'(w);
                found_invalid = 1'b1;
            end
        end
        if (!found_invalid) begin
            for (int w = 0; w < WAYS; w++) begin
                if (age_vec[w] > max_age) begin
                    max_age    = age_vec[w];
                    victim_way = AGE_BITS'(w);
                end
            end
        end
    end

    assign access_way = hit ? hit_way : victim_way;
    assign access_age = age_vec[access_way];

    genvar gi;
    generate
        for (gi = 0; gi < WAYS; gi++) begin : g_age
            assign next_age[gi] = (AGE_BITS'(gi) == access_way) ? '0 :
                                  (age_vec[gi] < access_age)   ? age_vec[gi] + AGE_BITS'(1) :
                                                                 age_vec[gi];
        end
    endgenerate

endmodule

// File: rtl/set_assoc_cache_model.sv
// N-way set-associative tag model: one lookup per cycle, hit/miss one cycle
// after acceptance, saturating totals and per-window hit counts.
module set_assoc_cache_model
    import cache_model_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int OFFSET_BITS = 2,
    parameter int INDEX_BITS  = 8,
    parameter int WAYS        = 2,
    parameter int CNT_W       = 21,
    parameter int WINDOW      = 1000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    set_assoc_cache_model_if.slave bus,
    input  logic                   flush,
    input  logic                   clr_stats,
    output logic [CNT_W-1:0]       hits,
    output logic [CNT_W-1:0]       misses,
    output logic                   win_valid,
    output logic [CNT_W-1:0]       win_hits
);
    localparam int SETS     = 2 ** INDEX_BITS;
    localparam int TAG_BITS = tag_width(ADDR_W, OFFSET_BITS, INDEX_BITS);
    localparam int AGE_BITS = age_width(WAYS);
    localparam int WIN_W    = $clog2(WINDOW + 1);

    state_t                        state_reg;
    logic [INDEX_BITS-1:0]         set_cnt_reg;
    logic [WAYS-1:0]               valid_reg [SETS];
    logic [TAG_BITS-1:0]           tag_mem   [SETS][WAYS];
    logic [WAYS-1:0][AGE_BITS-1:0] age_mem   [SETS];

    logic                  resp_valid_reg, resp_hit_reg, win_valid_reg;
    logic [CNT_W-1:0]      hits_reg, misses_reg, win_hits_reg, win_acc_reg;
    logic [WIN_W-1:0]      win_cnt_reg;

    logic                          req_ready, accept, hit;
    logic [INDEX_BITS-1:0]         acc_index;
    logic [TAG_BITS-1:0]           acc_tag;
    logic [WAYS-1:0]               way_hit;
    logic [AGE_BITS-1:0]           hit_way, victim_way;
    logic [WAYS-1:0][AGE_BITS-1:0] next_age;

    // A flush cycle never accepts, so the sweep cannot race a tag write
    assign req_ready = (state_reg == RUN) && !flush;
    assign accept    = bus.req_valid && req_ready;
    assign acc_index = INDEX_BITS'(addr_index(MAX_ADDR_W'(bus.req_addr), OFFSET_BITS, INDEX_BITS));
    assign acc_tag   = TAG_BITS'(addr_tag(MAX_ADDR_W'(bus.req_addr), OFFSET_BITS, INDEX_BITS));

    genvar gi;
    generate
        for (gi = 0; gi < WAYS; gi++) begin : g_cmp
            assign way_hit[gi] = valid_reg[acc_index][gi] && (tag_mem[acc_index][gi] == acc_tag);
        end
    endgenerate

    assign hit = |way_hit;

    always_comb begin
        hit_way = '0;
        for (int w = 0; w < WAYS; w++)
            if (way_hit[w]) hit_way = AGE_BITS'(w);
    end

    lru_age_update #(
        .WAYS     (WAYS),
        .AGE_BITS (AGE_BITS)
    ) u_lru (
        .age_vec    (age_mem[acc_index]),
        .valid_vec  (valid_reg[acc_index]),
        .hit        (hit),
        .hit_way    (hit_way),
        .victim_way (victim_way),
        .next_age   (next_age)
    );

    // Tags and ages need no reset: the INIT sweep reloads ages, valid bits gate tags
    always_ff @(posedge clk) begin
        if (state_reg == INIT) begin
            for (int w = 0; w < WAYS; w++)
                age_mem[set_cnt_reg][w] <= AGE_BITS'(w);
        end else if (accept) begin
            age_mem[acc_index] <= next_age;
            if (!hit)
                tag_mem[acc_index][victim_way] <= acc_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= INIT;
            set_cnt_reg    <= '0;
            for (int s = 0; s < SETS; s++)
                valid_reg[s] <= '0;
            resp_valid_reg <= 1'b0;
            resp_hit_reg   <= 1'b0;
            hits_reg       <= '0;
            misses_reg     <= '0;
            win_valid_reg  <= 1'b0;
            win_hits_reg   <= '0;
            win_acc_reg    <= '0;
            win_cnt_reg    <= '0;
        end else begin
            resp_valid_reg <= accept;
            resp_hit_reg   <= accept && hit;
            win_valid_reg  <= 1'b0;

            if (state_reg == INIT) begin
                valid_reg[set_cnt_reg] <= '0;
                set_cnt_reg            <= set_cnt_reg + INDEX_BITS'(1);
                if (32'(set_cnt_reg) == SETS - 1)
                    state_reg <= RUN;
            end else if (flush) begin
                state_reg   <= INIT;
                set_cnt_reg <= '0;
            end else if (accept && !hit) begin
                valid_reg[acc_index][victim_way] <= 1'b1;
            end

            // Statistics update on the edge that raises resp_valid, so totals
            // and the window pulse appear alongside the response they count
            if (clr_stats) begin
                hits_reg     <= '0;
                misses_reg   <= '0;
                win_hits_reg <= '0;
                win_acc_reg  <= '0;
                win_cnt_reg  <= '0;
            end else if (accept) begin
                hits_reg   <= CNT_W'(sat_inc(MAX_ADDR_W'(hits_reg), hit, CNT_W));
                misses_reg <= CNT_W'(sat_inc(MAX_ADDR_W'(misses_reg), !hit, CNT_W));
                if (32'(win_cnt_reg) + 32'd1 == 32'(WINDOW)) begin
                    win_valid_reg <= 1'b1;
                    win_hits_reg  <= CNT_W'(sat_inc(MAX_ADDR_W'(win_acc_reg), hit, CNT_W));
                    win_acc_reg   <= '0;
                    win_cnt_reg   <= '0;
                end else begin
                    win_acc_reg <= CNT_W'(sat_inc(MAX_ADDR_W'(win_acc_reg), hit, CNT_W));
                    win_cnt_reg <= win_cnt_reg + WIN_W'(1);
                end
            end
        end
    end

    assign bus.req_ready  = req_ready;
    assign bus.resp_valid = resp_valid_reg;
    assign bus.resp_hit   = resp_hit_reg;
    assign hits           = hits_reg;
    assign misses         = misses_reg;
    assign win_valid      = win_valid_reg;
    assign win_hits       = win_hits_reg;

endmodule

// File: tb/tb_set_assoc_cache_model.sv
// Directed bench for the cache tag model: table of accesses with expected
// hit/total/window values, plus reset, flush and clear corner sequences.
module tb_set_assoc_cache_model;
    localparam int ADDR_W      = 16;
    localparam int OFFSET_BITS = 2;
    localparam int INDEX_BITS  = 2;
    localparam int WAYS        = 2;
    localparam int CNT_W       = 3;
    localparam int WINDOW      = 4;
    localparam int NVEC        = 18;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             clr_stats = 1'b0;
    logic [CNT_W-1:0] hits, misses, win_hits;
    logic             win_valid;

    set_assoc_cache_model_if #(.ADDR_W(ADDR_W)) bus ();

    set_assoc_cache_model #(
        .ADDR_W      (ADDR_W),
        .OFFSET_BITS (OFFSET_BITS),
        .INDEX_BITS  (INDEX_BITS),
        .WAYS        (WAYS),
        .CNT_W       (CNT_W),
        .WINDOW      (WINDOW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .flush     (flush),
        .clr_stats (clr_stats),
        .hits      (hits),
        .misses    (misses),
        .win_valid (win_valid),
        .win_hits  (win_hits)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic              do_flush;
        logic [ADDR_W-1:0] addr;
        logic              exp_hit;
        int                exp_hits;
        int                exp_misses;
        logic              exp_win_valid;
        int                exp_win_hits;
    } vec_t;

    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic f, input logic [ADDR_W-1:0] a, input logic h,
                                input int eh, input int em, input logic wv, input int wh);
        vec_t v;
        v.do_flush = f; v.addr = a; v.exp_hit = h;
        v.exp_hits = eh; v.exp_misses = em; v.exp_win_valid = wv; v.exp_win_hits = wh;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; counts negedges with req_ready low, bounded
    task automatic wait_ready_low(output int n);
        n = 0;
        while (!bus.req_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
    endtask

    // Drives one request at a negedge; returns at the next negedge with the response visible
    task automatic access(input string name, input logic [ADDR_W-1:0] a);
        check({name, "_ready"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        @(posedge clk);
        @(negedge clk);
        check({name, "_resp_valid"}, 32'(bus.resp_valid), 32'd1);
    endtask

    task automatic flush_and_clear();
        int n;
        bus.req_valid = 1'b0;
        flush     = 1'b1;
        clr_stats = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush     = 1'b0;
        clr_stats = 1'b0;
        wait_ready_low(n);
        check("flush_sweep_len", 32'(n), 32'd4);
    endtask

    initial begin
        int n;
        string nm;

        // Set 0 addresses: 0x00, 0x10, 0x20 share index 0 with tags 0,1,2
        vecs[0]  = mk(0, 'h00, 0, 0, 1, 0, 0);
        vecs[1]  = mk(0, 'h00, 1, 1, 1, 0, 0);
        vecs[2]  = mk(1, 'h00, 0, 0, 1, 0, 0);
        vecs[3]  = mk(0, 'h10, 0, 0, 2, 0, 0);
        vecs[4]  = mk(0, 'h00, 1, 1, 2, 0, 0);
        vecs[5]  = mk(0, 'h20, 0, 1, 3, 1, 1);
        vecs[6]  = mk(0, 'h10, 0, 1, 4, 0, 1);
        vecs[7]  = mk(0, 'h00, 0, 1, 5, 0, 1);
        vecs[8]  = mk(1, 'h00, 0, 0, 1, 0, 0);
        vecs[9]  = mk(0, 'h00, 1, 1, 1, 0, 0);
        vecs[10] = mk(0, 'h00, 1, 2, 1, 0, 0);
        vecs[11] = mk(0, 'h00, 1, 3, 1, 1, 3);
        vecs[12] = mk(0, 'h00, 1, 4, 1, 0, 3);
        vecs[13] = mk(0, 'h00, 1, 5, 1, 0, 3);
        vecs[14] = mk(0, 'h00, 1, 6, 1, 0, 3);
        vecs[15] = mk(0, 'h00, 1, 7, 1, 1, 4);
        vecs[16] = mk(0, 'h00, 1, 7, 1, 0, 4);
        vecs[17] = mk(0, 'h00, 1, 7, 1, 0, 4);

        bus.req_valid = 1'b0;
        bus.req_addr  = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(bus.req_ready), 32'd0);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_hits", 32'(hits), 32'd0);
        check("rst_misses", 32'(misses), 32'd0);
        check("rst_win_valid", 32'(win_valid), 32'd0);
        check("rst_win_hits", 32'(win_hits), 32'd0);
        rst_n = 1'b1;
        wait_ready_low(n);
        check("rst_init_cycles", 32'(n), 32'd4);
        $display("reset: req_ready low for %0d cycles", n);

        for (int i = 0; i < NVEC; i++) begin
            if (vecs[i].do_flush) flush_and_clear();
            nm = $sformatf("v%0d", i);
            access(nm, vecs[i].addr);
            check({nm, "_hit"}, 32'(bus.resp_hit), 32'(vecs[i].exp_hit));
            check({nm, "_hits"}, 32'(hits), 32'(vecs[i].exp_hits));
            check({nm, "_misses"}, 32'(misses), 32'(vecs[i].exp_misses));
            check({nm, "_win_valid"}, 32'(win_valid), 32'(vecs[i].exp_win_valid));
            check({nm, "_win_hits"}, 32'(win_hits), 32'(vecs[i].exp_win_hits));
            $display("%s: addr=%0h hit=%0b hits=%0d misses=%0d win_valid=%0b win_hits=%0d",
                     nm, vecs[i].addr, bus.resp_hit, hits, misses, win_valid, win_hits);
        end
        bus.req_valid = 1'b0;

        // Flush with a request pending: not accepted, then a 4-cycle sweep
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_addr  = 'h00;
        flush         = 1'b1;
        #1;
        check("flush_ready_low", 32'(bus.req_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        flush         = 1'b0;
        bus.req_valid = 1'b0;
        check("flush_no_accept", 32'(bus.resp_valid), 32'd0);
        wait_ready_low(n);
        check("flush_low_cycles", 32'(n), 32'd4);
        access("flush_reissue", 'h00);
        check("flush_reissue_hit", 32'(bus.resp_hit), 32'd0);
        check("flush_reissue_misses", 32'(misses), 32'd2);
        check("flush_reissue_hits", 32'(hits), 32'd7);
        $display("flush: low=%0d reissue hit=%0b hits=%0d misses=%0d", n, bus.resp_hit, hits, misses);

        // clr_stats coinciding with an accepted hit: response stands, not counted
        clr_stats = 1'b1;
        access("clr_coincide", 'h00);
        clr_stats = 1'b0;
        check("clr_coincide_hit", 32'(bus.resp_hit), 32'd1);
        check("clr_coincide_hits", 32'(hits), 32'd0);
        check("clr_coincide_misses", 32'(misses), 32'd0);
        check("clr_coincide_win_hits", 32'(win_hits), 32'd0);
        access("clr_after", 'h00);
        check("clr_after_hit", 32'(bus.resp_hit), 32'd1);
        check("clr_after_hits", 32'(hits), 32'd1);
        check("clr_after_misses", 32'(misses), 32'd0);
        $display("clr_stats: coincident response dropped from totals, next hits=%0d", hits);

        // Reset with a response in flight
        bus.req_valid = 1'b1;
        bus.req_addr  = 'h00;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("midrst_ready", 32'(bus.req_ready), 32'd0);
        check("midrst_hits", 32'(hits), 32'd0);
        @(negedge clk);
        rst_n         = 1'b1;
        bus.req_valid = 1'b0;
        wait_ready_low(n);
        check("midrst_init_cycles", 32'(n), 32'd4);
        access("midrst_after", 'h00);
        check("midrst_after_hit", 32'(bus.resp_hit), 32'd0);
        check("midrst_after_misses", 32'(misses), 32'd1);
        bus.req_valid = 1'b0;
        $display("reset mid-op: sweep=%0d first access hit=%0b misses=%0d", n, bus.resp_hit, misses);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
